cont_scan_unit: RTL and testbench

CONT_SCAN_UNIT -- requirements
Module: cont_scan_unit

---
 rtl/cont_scan_unit.sv | 112 +++++++++++
 tb/tb_cont_scan_unit.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cont_scan_unit.sv
// Multi-cycle bit-run scanner: longest run of 1s, longest run of 0s, or count of 1-runs,
// scanning BPC bits per cycle from bit 0 upward behind a start/busy/done handshake.
module cont_scan_unit #(
  parameter int BPC = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] data,
  output logic        busy,
  output logic        done,
  output logic [31:0] out
);

  localparam int         N    = 32 / BPC;
  localparam logic [5:0] LAST = 6'(N - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  typedef struct packed {
    logic [5:0] run;
    logic [5:0] best;
    logic [5:0] cnt;
    logic       prev;
  } scan_t;

  state_t         state, state_nx;
  logic [31:0]    data_q;
  logic [1:0]     op_q;
  logic [5:0]     cyc;
  scan_t          sc, sc_nx;
  logic [5:0]     res_q, res_nx;
  logic [BPC-1:0] bits;
  logic           last;

  // Longest-zero-run reuses the ones datapath on inverted bits; prev=0 at start
  // makes a set bit 0 open a new run.
  function automatic scan_t scan_step(input scan_t s, input logic [BPC-1:0] b);
    scan_t r;
    r = s;
    for (int i = 0; i < BPC; i++) begin
      if (b[i]) begin
        if (!r.prev) r.cnt = r.cnt + 6'd1;
        r.run = r.run + 6'd1;
        if (r.run > r.best) r.best = r.run;
      end else begin
        r.run = 6'd0;
      end
      r.prev = b[i];
    end
    return r;
  endfunction

  function automatic logic [5:0] select_result(input scan_t s, input logic [1:0] o);
    case (o)
      2'b00, 2'b01: select_result = s.best;
      2'b10:        select_result = s.cnt;
      default:      select_result = 6'd0;
    endcase
  endfunction

  always_comb begin
    bits   = data_q[BPC-1:0] ^ {BPC{op_q == 2'b01}};
    sc_nx  = scan_step(sc, bits);
    res_nx = select_result(sc_nx, op_q);
    last   = (cyc == LAST);
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:    state_nx = start ? SCAN : IDLE;
      SCAN:    state_nx = last ? DONE : SCAN;
      DONE:    state_nx = start ? SCAN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SCAN);
    done = (state == DONE);
    out  = {26'd0, res_q};
  end

  // Operands latch only when a scan can begin; starts seen during SCAN are dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_q <= 32'd0;
      op_q   <= 2'b00;
      sc     <= '0;
      cyc    <= 6'd0;
      res_q  <= 6'd0;
    end else if (state != SCAN && start) begin
      data_q <= data;
      op_q   <= op;
      sc     <= '0;
      cyc    <= 6'd0;
    end else if (state == SCAN) begin
      data_q <= data_q >> BPC;
      sc     <= sc_nx;
      cyc    <= cyc + 6'd1;
      if (last) res_q <= res_nx;
    end
  end

endmodule

// File: tb/tb_cont_scan_unit.sv
// Directed bench for cont_scan_unit: one BPC=4 unit under full test, plus BPC=1/2/8 for latency.
module tb_cont_scan_unit;

  localparam int N4 = 8;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] data;
  logic        busy4, done4, busy1, done1, busy2, done2, busy8, done8;
  logic [31:0] out4, out1, out2, out8;

  int          checks;
  int          errors;
  logic [31:0] last_out;

  cont_scan_unit #(.BPC(4)) u4 (.clk(clk), .reset(reset), .start(start), .op(op), .data(data),
                                .busy(busy4), .done(done4), .out(out4));
  cont_scan_unit #(.BPC(1)) u1 (.clk(clk), .reset(reset), .start(start), .op(op), .data(data),
                                .busy(busy1), .done(done1), .out(out1));
  cont_scan_unit #(.BPC(2)) u2 (.clk(clk), .reset(reset), .start(start), .op(op), .data(data),
                                .busy(busy2), .done(done2), .out(out2));
  cont_scan_unit #(.BPC(8)) u8 (.clk(clk), .reset(reset), .start(start), .op(op), .data(data),
                                .busy(busy8), .done(done8), .out(out8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] d, input logic [1:0] o);
    data  = d;
    op    = o;
    start = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    issue(32'hFFFF_FFFF, 2'b00);
    repeat (3) tick;
    checks++;
    if ({busy4, done4} !== 2'b00) begin
      errors++;
      $display("FAIL reset_ctrl: busy/done=%b expected 00", {busy4, done4});
    end
    checks++;
    if (out4 !== 32'd0) begin
      errors++;
      $display("FAIL reset_out: out=%0d expected 0", out4);
    end
    checks++;
    if ({busy1, busy2, busy8, done1, done2, done8} !== 6'd0) begin
      errors++;
      $display("FAIL reset_others: busy/done=%b expected 000000", {busy1, busy2, busy8, done1, done2, done8});
    end
    reset = 1'b1;
    issue(32'h03F8_0F50, 2'b00);
    tick;
    start = 1'b0;
    checks++;
    if (busy4 !== 1'b1) begin
      errors++;
      $display("FAIL first_start_after_reset: busy=%b expected 1", busy4);
    end
    repeat (40) tick;
    checks++;
    if (out4 !== 32'd7) begin
      errors++;
      $display("FAIL first_start_result: out=%0d expected 7", out4);
    end
    last_out = 32'd7;
  endtask

  task automatic test_scan_results;
    logic [31:0] vd [12];
    logic [1:0]  vo [12];
    logic [5:0]  ve [12];
    vd = '{32'h03F8_0F50, 32'h03F8_0F50, 32'h03F8_0F50, 32'h03F8_0F50,
           32'hFFFF_FFFF, 32'h0000_0000, 32'hAAAA_AAAA, 32'h8000_0001,
           32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vo = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b10, 2'b01, 2'b10};
    ve = '{6'd7, 6'd7, 6'd4, 6'd0, 6'd32, 6'd32, 6'd16, 6'd1, 6'd0, 6'd0, 6'd0, 6'd1};
    for (int i = 0; i < 12; i++) begin
      issue(vd[i], vo[i]);
      for (int k = 1; k <= N4 + 1; k++) begin
        tick;
        start = 1'b0;
        checks++;
        if ({busy4, done4} !== {(k <= N4), (k == N4 + 1)}) begin
          errors++;
          $display("FAIL scan_timing v%0d cyc%0d: busy/done=%b expected %b", i, k, {busy4, done4},
                   {(k <= N4), (k == N4 + 1)});
        end
        if (k <= N4) begin
          checks++;
          if (out4 !== last_out) begin
            errors++;
            $display("FAIL scan_out_hold v%0d cyc%0d: out=%0d expected %0d", i, k, out4, last_out);
          end
        end
      end
      checks++;
      if (out4 !== {26'd0, ve[i]}) begin
        errors++;
        $display("FAIL scan_result v%0d data=%h op=%b: out=%0d expected %0d", i, vd[i], vo[i], out4, ve[i]);
      end
      last_out = {26'd0, ve[i]};
      tick;
      checks++;
      if ({busy4, done4} !== 2'b00 || out4 !== last_out) begin
        errors++;
        $display("FAIL scan_idle v%0d: busy/done=%b out=%0d expected 00 out=%0d", i, {busy4, done4}, out4, last_out);
      end
    end
  endtask

  task automatic test_start_ignored;
    issue(32'h03F8_0F50, 2'b00);
    for (int k = 1; k <= N4 + 1; k++) begin
      tick;
      start = 1'b0;
      if (k == 3) issue(32'hFFFF_FFFF, 2'b10);
      checks++;
      if ({busy4, done4} !== {(k <= N4), (k == N4 + 1)}) begin
        errors++;
        $display("FAIL ignore_timing cyc%0d: busy/done=%b expected %b", k, {busy4, done4},
                 {(k <= N4), (k == N4 + 1)});
      end
    end
    checks++;
    if (out4 !== 32'd7) begin
      errors++;
      $display("FAIL ignore_result: out=%0d expected 7", out4);
    end
    tick;
    checks++;
    if ({busy4, done4} !== 2'b00) begin
      errors++;
      $display("FAIL ignore_no_restart: busy/done=%b expected 00", {busy4, done4});
    end
    last_out = 32'd7;
  endtask

  task automatic test_back_to_back;
    issue(32'h03F8_0F50, 2'b10);
    for (int k = 1; k <= N4 + 1; k++) begin
      tick;
      start = 1'b0;
      checks++;
      if ({busy4, done4} !== {(k <= N4), (k == N4 + 1)}) begin
        errors++;
        $display("FAIL b2b_first cyc%0d: busy/done=%b expected %b", k, {busy4, done4},
                 {(k <= N4), (k == N4 + 1)});
      end
    end
    checks++;
    if (out4 !== 32'd4) begin
      errors++;
      $display("FAIL b2b_first_result: out=%0d expected 4", out4);
    end
    issue(32'hAAAA_AAAA, 2'b10);
    for (int k = 1; k <= N4 + 1; k++) begin
      tick;
      start = 1'b0;
      checks++;
      if ({busy4, done4} !== {(k <= N4), (k == N4 + 1)}) begin
        errors++;
        $display("FAIL b2b_second cyc%0d: busy/done=%b expected %b", k, {busy4, done4},
                 {(k <= N4), (k == N4 + 1)});
      end
      if (k <= N4) begin
        checks++;
        if (out4 !== 32'd4) begin
          errors++;
          $display("FAIL b2b_hold cyc%0d: out=%0d expected 4", k, out4);
        end
      end
    end
    checks++;
    if (out4 !== 32'd16) begin
      errors++;
      $display("FAIL b2b_second_result: out=%0d expected 16", out4);
    end
    tick;
    last_out = 32'd16;
  endtask

  task automatic test_reset_mid_scan;
    int seen_done;
    seen_done = 0;
    issue(32'hFFFF_FFFF, 2'b00);
    for (int k = 1; k <= 3; k++) begin
      tick;
      start = 1'b0;
    end
    reset = 1'b0;
    tick;
    checks++;
    if ({busy4, done4} !== 2'b00 || out4 !== 32'd0) begin
      errors++;
      $display("FAIL midscan_reset: busy/done=%b out=%0d expected 00 out=0", {busy4, done4}, out4);
    end
    reset = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick;
      if (done4) seen_done++;
    end
    checks++;
    if (seen_done !== 0 || out4 !== 32'd0) begin
      errors++;
      $display("FAIL midscan_aftermath: done pulses=%0d out=%0d expected 0 and 0", seen_done, out4);
    end
    issue(32'h03F8_0F50, 2'b00);
    for (int k = 1; k <= N4 + 1; k++) begin
      tick;
      start = 1'b0;
      checks++;
      if ({busy4, done4} !== {(k <= N4), (k == N4 + 1)}) begin
        errors++;
        $display("FAIL midscan_fresh cyc%0d: busy/done=%b expected %b", k, {busy4, done4},
                 {(k <= N4), (k == N4 + 1)});
      end
    end
    checks++;
    if (out4 !== 32'd7) begin
      errors++;
      $display("FAIL midscan_fresh_result: out=%0d expected 7", out4);
    end
    tick;
    last_out = 32'd7;
  endtask

  task automatic test_bpc_variants;
    int d1, d2, d4, d8;
    logic [31:0] o1, o2, o4, o8;
    d1 = 0; d2 = 0; d4 = 0; d8 = 0;
    o1 = '1; o2 = '1; o4 = '1; o8 = '1;
    reset = 1'b0;
    start = 1'b0;
    tick;
    reset = 1'b1;
    issue(32'h03F8_0F50, 2'b00);
    for (int k = 1; k <= 40; k++) begin
      tick;
      start = 1'b0;
      if (done1 && d1 == 0) begin d1 = k; o1 = out1; end
      if (done2 && d2 == 0) begin d2 = k; o2 = out2; end
      if (done4 && d4 == 0) begin d4 = k; o4 = out4; end
      if (done8 && d8 == 0) begin d8 = k; o8 = out8; end
    end
    checks++;
    if (d1 !== 33 || o1 !== 32'd7) begin
      errors++;
      $display("FAIL bpc1: done at %0d out=%0d expected 33 and 7", d1, o1);
    end
    checks++;
    if (d2 !== 17 || o2 !== 32'd7) begin
      errors++;
      $display("FAIL bpc2: done at %0d out=%0d expected 17 and 7", d2, o2);
    end
    checks++;
    if (d4 !== 9 || o4 !== 32'd7) begin
      errors++;
      $display("FAIL bpc4: done at %0d out=%0d expected 9 and 7", d4, o4);
    end
    checks++;
    if (d8 !== 5 || o8 !== 32'd7) begin
      errors++;
      $display("FAIL bpc8: done at %0d out=%0d expected 5 and 7", d8, o8);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    last_out = 32'd0;
    reset    = 1'b0;
    start    = 1'b0;
    op       = 2'b00;
    data     = 32'd0;
    test_reset;
    test_scan_results;
    test_start_ignored;
    test_back_to_back;
    test_reset_mid_scan;
    test_bpc_variants;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
